// File: rtl/ghr_spec_ctrl_pkg.sv
// Shared branch-predictor types for the speculative global-history controller.
// Holds the direction type and the recovery FSM state encoding.
package ghr_spec_ctrl_pkg;

    typedef logic dir_t;

    localparam dir_t DIR_NOT_TAKEN = 1'b0;
    localparam dir_t DIR_TAKEN     = 1'b1;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_e;

endpackage

// File: rtl/ghr_dir_fifo.sv
// Circular FIFO of in-flight predicted branch directions (1 bit per entry).
// Clear has priority over push/pop; pointers wrap modulo DEPTH.
module ghr_dir_fifo
    import ghr_spec_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  dir_t                     din_i,
    input  logic                     pop_i,
    output dir_t                     head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    dir_t          mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next pointers and occupancy; a clear collapses head onto tail.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (do_push) tail_d = tail_q + PW'(1);
            if (do_pop)  head_d = head_q + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Direction storage, written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= DIR_NOT_TAKEN;
        end else if (!clear_i && do_push) begin
            mem_q[tail_q] <= din_i;
        end
    end

endmodule

// File: rtl/ghr_spec_ctrl.sv
// Speculative / architectural global-history controller with mispredict recovery.
// Optional resolve/mispredict counters when GHR_SPEC_CTRL_STATS_EN is defined.
module ghr_spec_ctrl
    import ghr_spec_ctrl_pkg::*;
#(
    parameter int HISTORY_SIZE = 64,
    parameter int DEPTH        = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    output logic [HISTORY_SIZE-1:0]  spec_history,
    input  logic                     ex_valid,
    input  logic                     ex_taken,
    output logic                     ex_mispredict,
    input  logic                     flush,
    output logic [HISTORY_SIZE-1:0]  arch_history,
    output logic [$clog2(DEPTH):0]   inflight,
    output logic                     underflow_err
`ifdef GHR_SPEC_CTRL_STATS_EN
    ,
    output logic [31:0]              stat_resolved,
    output logic [31:0]              stat_mispredict
`endif
);

    state_e                  state_q, state_d;
    logic [HISTORY_SIZE-1:0] spec_q, spec_d;
    logic [HISTORY_SIZE-1:0] arch_q, arch_d;
    logic                    uf_q;

    dir_t                    fifo_head;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    push_acc;
    logic                    resolve;
    logic                    mispredict;
    logic                    recover_ev;

    assign push_acc      = pred_valid & pred_ready;
    assign resolve       = ex_valid & ~fifo_empty;
    assign mispredict    = resolve & (fifo_head != dir_t'(ex_taken));
    assign recover_ev    = mispredict | flush;
    assign ex_mispredict = mispredict;

    ghr_dir_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (recover_ev),
        .push_i  (push_acc & ~recover_ev),
        .din_i   (dir_t'(pred_taken)),
        .pop_i   (resolve & ~recover_ev),
        .head_o  (fifo_head),
        .count_o (inflight),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM next state: any recovery event holds off fetch for one cycle.
    always_comb begin
        state_d = RUN;
        if (recover_ev) state_d = RECOVER;
    end

    // FSM outputs: full is taken from the registered count only.
    always_comb begin
        pred_ready = 1'b0;
        unique case (state_q)
            RUN:     pred_ready = ~fifo_full;
            RECOVER: pred_ready = 1'b0;
            default: pred_ready = 1'b0;
        endcase
    end

    // History next state; recovery reloads spec from the updated arch value.
    always_comb begin
        arch_d = arch_q;
        spec_d = spec_q;
        if (resolve) arch_d = {arch_q[HISTORY_SIZE-2:0], ex_taken};
        if (recover_ev) begin
            spec_d = arch_d;
        end else if (push_acc) begin
            spec_d = {spec_q[HISTORY_SIZE-2:0], pred_taken};
        end
    end

    // History registers and sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_q <= '0;
            arch_q <= '0;
            uf_q   <= 1'b0;
        end else begin
            spec_q <= spec_d;
            arch_q <= arch_d;
            if (ex_valid && fifo_empty) uf_q <= 1'b1;
        end
    end

    assign spec_history  = spec_q;
    assign arch_history  = arch_q;
    assign underflow_err = uf_q;

`ifdef GHR_SPEC_CTRL_STATS_EN
    logic [31:0] stat_res_q;
    logic [31:0] stat_mis_q;

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (resolve && stat_res_q != '1)    stat_res_q <= stat_res_q + 32'd1;
            if (mispredict && stat_mis_q != '1) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_resolved   = stat_res_q;
    assign stat_mispredict = stat_mis_q;
`endif

endmodule
